// File: rtl/fuzz_stim_driver.sv
// fuzz_stim_driver
// Drives pseudo-random 96-bit stimulus into one fuzz top, waits a fixed
// settle time, then folds the DUT response into a 32-bit MISR signature.
// A complete vector run therefore reduces to a single comparable word.
//
// Ports:
//   clkin_data    clock, rising edge
//   rstin_data_n  asynchronous active-low reset
//   start         begin a run (honoured only in IDLE or DONE)
//   seed          LFSR seed, captured on an accepted start
//   num_vectors   vectors per run, captured on an accepted start
//   dut_in_data   registered stimulus to the DUT in_data bus
//   dut_out_data  DUT out_data bus, sampled in CAPTURE
//   busy          high in DRIVE, WAIT, CAPTURE
//   done          high in DONE, held until the next accepted start
//   vec_count     vectors captured in the current run
//   probe_data    MISR signature
//
// Optional build macro STIM_ABORT_EN adds:
//   abort         forces DONE from DRIVE/WAIT/CAPTURE, discarding pending work
//   aborted       flags a run that ended through abort
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// DRIVE   | launch {L2,L1,L0} onto dut_in_data
// WAIT    | settle counter running down
// CAPTURE | fold dut_out_data into MISR, advance LFSRs, count vector
// DONE    | run finished, signature stable, waiting for start
module fuzz_stim_driver #(
    parameter int DATA_W        = 96,
    parameter int SIG_W         = 32,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clkin_data,
    input  logic              rstin_data_n,
    input  logic              start,
    input  logic [SIG_W-1:0]  seed,
    input  logic [CNT_W-1:0]  num_vectors,
    output logic [DATA_W-1:0] dut_in_data,
    input  logic [DATA_W-1:0] dut_out_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  vec_count,
    output logic [SIG_W-1:0]  probe_data
`ifdef STIM_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    localparam logic [SIG_W-1:0] TAPS       = 32'h80200003;
    localparam logic [SIG_W-1:0] SIG_INIT   = 32'hFFFFFFFF;
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [SIG_W-1:0]  l0, l1, l2;
    logic [CNT_W-1:0]  num_lat;
    logic [3:0]        settle_cnt;
    logic              start_ok;
    logic              abort_hit;
    logic [CNT_W-1:0]  vec_count_inc;
    logic [SIG_W-1:0]  fold;

    function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : '0);
    endfunction

    // An all-zero word would lock the Galois LFSR at zero forever.
    function automatic logic [SIG_W-1:0] non_zero(input logic [SIG_W-1:0] x);
        return (x == '0) ? 32'h00000001 : x;
    endfunction

    assign busy          = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CAPTURE);
    assign start_ok      = start && ((state == S_IDLE) || (state == S_DONE));
    assign vec_count_inc = vec_count + CNT_W'(1);
    assign fold          = dut_out_data[31:0] ^ dut_out_data[63:32] ^ dut_out_data[95:64];

`ifdef STIM_ABORT_EN
    assign abort_hit = abort && busy;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clkin_data or negedge rstin_data_n) begin
        if (!rstin_data_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_nxt = (num_vectors == '0) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_nxt = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (settle_cnt <= 4'd1) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nxt = (vec_count_inc == num_lat) ? S_DONE : S_DRIVE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clkin_data or negedge rstin_data_n) begin
        if (!rstin_data_n) begin
            dut_in_data <= '0;
            done        <= 1'b0;
            vec_count   <= '0;
            probe_data  <= SIG_INIT;
            l0          <= '0;
            l1          <= '0;
            l2          <= '0;
            num_lat     <= '0;
            settle_cnt  <= '0;
`ifdef STIM_ABORT_EN
            aborted     <= 1'b0;
`endif
        end else if (abort_hit) begin
            // Pending work is dropped; signature and count keep the last
            // fully captured vector.
            done <= 1'b1;
`ifdef STIM_ABORT_EN
            aborted <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        l0         <= non_zero(seed);
                        l1         <= non_zero(seed ^ 32'h5A5A5A5A);
                        l2         <= non_zero(seed ^ 32'hA5A5A5A5);
                        num_lat    <= num_vectors;
                        vec_count  <= '0;
                        probe_data <= SIG_INIT;
                        done       <= 1'b0;
`ifdef STIM_ABORT_EN
                        aborted    <= 1'b0;
`endif
                    end else if (state == S_DONE) begin
                        // Zero-length runs land here with done low and
                        // raise it one cycle later.
                        done <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    dut_in_data <= {l2, l1, l0};
                    settle_cnt  <= SETTLE_INIT;
                end
                S_WAIT: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                S_CAPTURE: begin
                    probe_data <= lfsr_step(probe_data) ^ fold;
                    l0         <= lfsr_step(l0);
                    l1         <= lfsr_step(l1);
                    l2         <= lfsr_step(l2);
                    vec_count  <= vec_count_inc;
                    if (vec_count_inc == num_lat) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
